mul_rep_add_unit: RTL
=====================

Name: mul_rep_add_unit

Overview:
Parametrised sequential multiplier using repeated addition. Controller FSM and datapath are integrated behind a start/done handshake.
- Successor to the fixed 16-bit shared-bus multiplier datapath: independent operand ports, WIDTH-generic, full 2*WIDTH product.
- Operand swap: the smaller operand becomes the iteration count, so latency tracks min(a,b).
- Sits as a slave compute unit under a sequencer that issues start and waits for done.

Parameters:
WIDTH, 16, operand width in bits (>=2); product is 2*WIDTH bits.

Ports:
clk  input  1  rising-edge clock; single clock domain
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
a_in  input  WIDTH  multiplicand operand; captured on accepted start
b_in  input  WIDTH  multiplier operand; captured on accepted start
busy  output  1  high in RUN state
done  output  1  one-cycle pulse; product valid
product  output  2*WIDTH  result register; held until next accepted start

Behaviour:
- Reset: state=IDLE, busy=0, done=0, product=0, internal regs=0. Reset asserted mid-RUN aborts with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at edge k:
  - addend reg <= max(a,b), zero-extended to 2*WIDTH.
  - count reg <= min(a,b); a==b counts as min=b.
  - product <= 0.
  - state <= RUN.
- RUN:
  - If count!=0: product <= product + addend; count <= count-1.
  - If count==0: state <= DONE.
  - No add occurs in the cycle that sees count==0.
- DONE: done=1 for exactly one cycle; state <= IDLE unconditionally. start ignored here.
- Latency: start sampled at edge k -> done high in the cycle after edge k+min(a,b)+1. A zero operand gives done after edge k+1 with product=0.
- start while busy or done=1: ignored, no effect on operands or result.
- Arithmetic: unsigned, 2*WIDTH accumulator. The sum never overflows because max result is (2^WIDTH-1)^2.
- Worst-case iterations: 2^WIDTH-1. Count reg is WIDTH bits.
- product is visible while RUN (partial sums). Consumers sample it only on done or later.

Optional Feature:
Macro MUL_SIGNED_EN.
- Defined: a_in/b_in are two's complement.
  - At start capture: magnitudes |a|, |b| as WIDTH-bit unsigned (-2^(WIDTH-1) maps to 2^(WIDTH-1)). sign_r <= a[MSB]^b[MSB].
  - Swap and iteration run on magnitudes.
  - On RUN->DONE transition: product <= sign_r ? -product : product (2*WIDTH two's complement). done timing unchanged.
- Undefined: purely unsigned, no sign register, no negation logic.

Decomposition:
- Shared package mul_pkg:
  - state enum typedef (IDLE, RUN, DONE).
  - localparam helpers for product width (2*WIDTH) and state encoding width.
- One sub-module, mul_rep_add_dp, holds the datapath:
  - operand compare/swap
  - addend, count and product registers
  - adder
  - count==0 detect (cnt_zero)
  - conditional negate (under macro)
- Top holds the FSM, drives ld/add/dec/neg strobes, and consumes cnt_zero.

Test Plan:
- a=5, b=3, start 1 cycle -> busy for 4 cycles; done pulse once; product=15; done 5 edges after start edge.
- a=3, b=200 (swap check) -> product=600 with same latency as a=200, b=3 (min=3 iterations).
- a=0, b=65535 -> done after edge k+1, product=0; then a=65535, b=65535 -> product=0xFFFE0001 after 65536 RUN cycles.
- Mid-RUN: pulse start with new operands (ignored), then assert rst -> busy=0, done never pulses, product=0; next start 7*6 -> 42.
- Back-to-back: start held high continuously -> new operation accepted only in IDLE, i.e. the cycle after each done pulse; products correct for each.
- MUL_SIGNED_EN, WIDTH=16: -3*5 -> 0xFFFFFFF1; -32768*-1 -> 0x00008000; -4*-4 -> 16; latency still min(|a|,|b|)+2 edges.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and width helpers for the repeated-addition multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional feature macro used by the users of this package: MUL_SIGNED_EN.
package mul_pkg;

  // Default operand width; the product is always twice this.
  localparam int DEFAULT_WIDTH = 16;

  // Encoding width of the controller state.
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  // Product width for a given operand width.
  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/mul_rep_add_dp.sv
// Datapath of the repeated-addition multiplier: operand swap, addend/count/product regs, adder.
// Latency: registers update on the edge after the strobe is presented; cnt_zero_o is combinational.
// Backpressure: none; strictly a slave of the controller strobes.
// Ports: ld_i loads operands (clears product), add_i accumulates, dec_i decrements count,
//        neg_i (MUL_SIGNED_EN only) applies the captured sign; product_o, cnt_zero_o out.
module mul_rep_add_dp
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ld_i,
  input  logic                      add_i,
  input  logic                      dec_i,
`ifdef MUL_SIGNED_EN
  input  logic                      neg_i,
`endif
  input  logic [WIDTH-1:0]          a_i,
  input  logic [WIDTH-1:0]          b_i,
  output logic [prod_w(WIDTH)-1:0]  product_o,
  output logic                      cnt_zero_o
);

  localparam int PW = prod_w(WIDTH);
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] op_min, op_max;
  logic [PW-1:0]    addend_q, addend_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    prod_q, prod_d;

`ifdef MUL_SIGNED_EN
  logic sign_q, sign_d;

  // Magnitudes as unsigned WIDTH-bit values; the most negative input maps
  // onto 2^(WIDTH-1), which still fits unsigned.
  assign a_mag = a_i[WIDTH-1] ? ('0 - a_i) : a_i;
  assign b_mag = b_i[WIDTH-1] ? ('0 - b_i) : b_i;
`else
  assign a_mag = a_i;
  assign b_mag = b_i;
`endif

  // Smaller operand drives the iteration count; ties go to b.
  always_comb begin
    op_min = b_mag;
    op_max = a_mag;
    if (a_mag < b_mag) begin
      op_min = a_mag;
      op_max = b_mag;
    end
  end

  always_comb begin
    addend_d = addend_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
`ifdef MUL_SIGNED_EN
    sign_d   = sign_q;
`endif
    if (ld_i) begin
      addend_d = {{WIDTH{1'b0}}, op_max};
      cnt_d    = op_min;
      prod_d   = '0;
`ifdef MUL_SIGNED_EN
      sign_d   = a_i[WIDTH-1] ^ b_i[WIDTH-1];
`endif
    end else begin
      if (add_i) prod_d = prod_q + addend_q;
      if (dec_i) cnt_d  = cnt_q - CNT_ONE;
`ifdef MUL_SIGNED_EN
      // Applied once, on the final RUN cycle, when no add is in flight.
      if (neg_i && sign_q) prod_d = '0 - prod_q;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addend_q <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
`ifdef MUL_SIGNED_EN
      sign_q   <= 1'b0;
`endif
    end else begin
      addend_q <= addend_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
`ifdef MUL_SIGNED_EN
      sign_q   <= sign_d;
`endif
    end
  end

  assign product_o  = prod_q;
  assign cnt_zero_o = (cnt_q == '0);

endmodule

// File: rtl/mul_rep_add_unit.sv
// Sequential multiplier by repeated addition with start/done handshake (MUL_SIGNED_EN: signed operands).
// Latency: start accepted at edge k -> done high after edge k+min(a,b)+1 for one cycle.
// Backpressure: start is only honoured in IDLE; ignored while busy or done.
// Ports: clk, rst (sync, high), start, a_in, b_in in; busy, done, product (2*WIDTH) out.
module mul_rep_add_unit
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WIDTH-1:0]          a_in,
  input  logic [WIDTH-1:0]          b_in,
  output logic                      busy,
  output logic                      done,
  output logic [prod_w(WIDTH)-1:0]  product
);

  mul_state_e state_q, state_d;
  logic       ld, add, dec, cnt_zero;
`ifdef MUL_SIGNED_EN
  logic       neg;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    add     = 1'b0;
    dec     = 1'b0;
`ifdef MUL_SIGNED_EN
    neg     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ld      = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // The cycle that observes a zero count does no add; it only exits.
        if (!cnt_zero) begin
          add = 1'b1;
          dec = 1'b1;
        end else begin
          state_d = DONE;
`ifdef MUL_SIGNED_EN
          neg     = 1'b1;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  mul_rep_add_dp #(.WIDTH(WIDTH)) u_dp (
    .clk        (clk),
    .rst        (rst),
    .ld_i       (ld),
    .add_i      (add),
    .dec_i      (dec),
`ifdef MUL_SIGNED_EN
    .neg_i      (neg),
`endif
    .a_i        (a_in),
    .b_i        (b_in),
    .product_o  (product),
    .cnt_zero_o (cnt_zero)
  );

endmodule
